// File: rtl/datapath_stream_host.sv
// datapath_stream_host: streams a memory block through the 64-bit negator datapath and writes the results back
module datapath_stream_host #(
    parameter int ADDR_WIDTH = 8,
    parameter int ISSUE_GAP  = 0,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [63:0]           mem_rd_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [63:0]           mem_wr_data,
    output logic                  dp_input_valid,
    output logic [63:0]           dp_input_data,
    input  logic                  dp_output_valid,
    input  logic [63:0]           dp_output_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int AW = ADDR_WIDTH;
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, READ, CAPTURE, SEND, GAP, DRAIN} state_t;
    state_t        state;
    logic [AW-1:0] src, dst;
    logic [AW:0]   len, rd_count, wr_count, rd_next;
    logic [TW-1:0] tmo;
    logic [15:0]   gap_cnt;
    assign rd_next = rd_count + 1'b1;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            src            <= '0;
            dst            <= '0;
            len            <= '0;
            rd_count       <= '0;
            wr_count       <= '0;
            tmo            <= '0;
            gap_cnt        <= '0;
            mem_rd_en      <= 1'b0;
            mem_rd_addr    <= '0;
            mem_wr_en      <= 1'b0;
            mem_wr_addr    <= '0;
            mem_wr_data    <= '0;
            dp_input_valid <= 1'b0;
            dp_input_data  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            mem_rd_en      <= 1'b0;
            mem_wr_en      <= 1'b0;
            dp_input_valid <= 1'b0;
            done           <= 1'b0;
            // write-back runs beside the read FSM for as long as a command is active
            if (busy && dp_output_valid) begin
                mem_wr_en   <= 1'b1;
                mem_wr_addr <= dst + wr_count[AW-1:0];
                mem_wr_data <= dp_output_data;
                wr_count    <= wr_count + 1'b1;
            end
            case (state)
                IDLE: if (start) begin
                    src      <= src_addr;
                    dst      <= dst_addr;
                    len      <= length;
                    rd_count <= '0;
                    wr_count <= '0;
                    error    <= 1'b0;
                    if (length == '0) begin
                        done <= 1'b1;
                    end else begin
                        state       <= READ;
                        busy        <= 1'b1;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= src_addr;
                    end
                end
                READ: state <= CAPTURE;
                CAPTURE: begin
                    dp_input_data  <= mem_rd_data;
                    dp_input_valid <= 1'b1;
                    state          <= SEND;
                end
                SEND: begin
                    rd_count <= rd_next;
                    tmo      <= '0;
                    gap_cnt  <= '0;
                    if (ISSUE_GAP > 0) begin
                        state <= GAP;
                    end else if (rd_next < len) begin
                        state       <= READ;
                        mem_rd_en   <= 1'b1;
                        mem_rd_addr <= src + rd_next[AW-1:0];
                    end else begin
                        state <= DRAIN;
                    end
                end
                GAP: begin
                    if (gap_cnt == 16'(ISSUE_GAP - 1)) begin
                        if (rd_count < len) begin
                            state       <= READ;
                            mem_rd_en   <= 1'b1;
                            mem_rd_addr <= src + rd_count[AW-1:0];
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (wr_count == len) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (dp_output_valid) begin
                        tmo <= '0;
                    end else if (tmo == TW'(TIMEOUT - 1)) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_datapath_stream_host.sv
// tb_datapath_stream_host: directed vectors against a memory model and a lane-negating datapath stub
module tb_datapath_stream_host;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  src_addr = '0, dst_addr = '0;
    logic [8:0]  length = '0;
    logic        mem_rd_en, mem_wr_en, dp_input_valid, dp_output_valid, busy, done, error;
    logic [7:0]  mem_rd_addr, mem_wr_addr;
    logic [63:0] mem_rd_data, mem_wr_data, dp_input_data, dp_output_data;

    datapath_stream_host #(.ADDR_WIDTH(8), .ISSUE_GAP(0), .TIMEOUT(16)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .dp_input_valid(dp_input_valid), .dp_input_data(dp_input_data),
        .dp_output_valid(dp_output_valid), .dp_output_data(dp_output_data),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] src;
        logic [7:0] dst;
        logic [8:0] len;
        logic [7:0] mask;
        int         lat;
        logic       err;
        logic       poke;
    } vec_t;
    typedef struct {int c; logic [63:0] d;} pulse_t;
    typedef struct {logic [7:0] a; logic [63:0] d;} wr_t;

    logic [63:0] mem [256];
    logic [63:0] snap [256];
    int          cyc = 0;
    int          errors = 0, checks = 0;
    int          done_cnt = 0;
    int          pidx = 0;
    logic [7:0]  resp_mask = 8'hFF;
    logic        spur = 1'b0;
    logic        v1 = 1'b0, v2 = 1'b0;
    logic [63:0] d1 = '0, d2 = '0;
    logic [7:0]  rlog[$];
    wr_t         wlog[$];
    pulse_t      plog[$];

    function automatic logic [63:0] neg(input logic [63:0] x);
        return {-x[63:32], -x[31:0]};
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
        if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end

    // datapath stand-in: two-cycle latency, answers only pulses enabled in resp_mask
    always @(posedge clock) begin
        v1 <= dp_input_valid && (pidx > 7 || resp_mask[pidx[2:0]]);
        d1 <= neg(dp_input_data);
        v2 <= v1;
        d2 <= d1;
        if (dp_input_valid) pidx <= pidx + 1;
    end
    assign dp_output_valid = v2 | spur;
    assign dp_output_data  = d2;

    always @(negedge clock) if (reset_n) begin
        if (mem_rd_en) rlog.push_back(mem_rd_addr);
        if (mem_wr_en) wlog.push_back('{mem_wr_addr, mem_wr_data});
        if (dp_input_valid) plog.push_back('{cyc, dp_input_data});
        if (done) done_cnt++;
    end

    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic chk_outputs_zero(input string n);
        chk(n, {mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
                dp_input_valid, dp_input_data, busy, done, error}, '0);
    endtask

    task automatic run(input vec_t v);
        int          t0, td, bad;
        logic [63:0] ew[$];
        snap = mem;
        rlog.delete(); wlog.delete(); plog.delete();
        done_cnt = 0; pidx = 0; resp_mask = v.mask;
        src_addr = v.src; dst_addr = v.dst; length = v.len;
        start = 1'b1; spur = v.poke;
        t0 = cyc;
        @(negedge clock);
        start = 1'b0; spur = 1'b0;
        chk("busy_t1", busy, v.len != 0);
        chk("error_t1", error, 1'b0);
        td = -1;
        for (int i = 0; i < 300; i++) begin
            if (done) begin td = cyc; break; end
            start = v.poke && i == 3;
            @(negedge clock);
        end
        start = 1'b0;
        chk("done_latency", td - t0, v.lat);
        chk("busy_at_done", busy, 1'b0);
        chk("error_at_done", error, v.err);
        repeat (4) @(negedge clock);
        chk("done_count", done_cnt, 1);
        chk("pulse_count", plog.size(), v.len);
        if (plog.size() > 0) chk("first_pulse", plog[0].c - t0, 3);
        bad = 0;
        for (int i = 0; i < plog.size(); i++) begin
            if (i > 0 && plog[i].c - plog[i-1].c != 3) bad++;
            if (plog[i].d !== snap[v.src + 8'(i)]) bad++;
        end
        chk("pulse_bad", bad, 0);
        chk("read_count", rlog.size(), v.len);
        bad = 0;
        for (int i = 0; i < rlog.size(); i++) if (rlog[i] !== v.src + 8'(i)) bad++;
        chk("read_addr_bad", bad, 0);
        for (int i = 0; i < v.len; i++)
            if (i > 7 || v.mask[i]) ew.push_back(neg(snap[v.src + 8'(i)]));
        chk("write_count", wlog.size(), ew.size());
        bad = 0;
        for (int k = 0; k < wlog.size() && k < ew.size(); k++)
            if (wlog[k].a !== v.dst + 8'(k) || wlog[k].d !== ew[k]) bad++;
        chk("write_bad", bad, 0);
    endtask

    vec_t tv[6];
    vec_t rv;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        mem[8'h10] = 64'h00000002_00000001;
        tv[0] = '{8'h10, 8'h80, 9'd1, 8'hFF, 7,  1'b0, 1'b0};
        tv[1] = '{8'h20, 8'h90, 9'd8, 8'hFF, 28, 1'b0, 1'b0};
        tv[2] = '{8'h30, 8'hA0, 9'd0, 8'hFF, 1,  1'b0, 1'b0};
        tv[3] = '{8'h40, 8'hB0, 9'd4, 8'h0C, 31, 1'b1, 1'b0};
        tv[4] = '{8'h50, 8'hC0, 9'd2, 8'hFF, 10, 1'b0, 1'b0};
        tv[5] = '{8'hFE, 8'hFE, 9'd4, 8'hFF, 16, 1'b0, 1'b1};
        rv    = '{8'h60, 8'hD0, 9'd3, 8'hFF, 13, 1'b0, 1'b0};
        repeat (3) @(negedge clock);
        chk_outputs_zero("reset_outputs");
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 6; i++) run(tv[i]);
        chk("single_word_dst", mem[8'h80], 64'hFFFFFFFE_FFFFFFFF);

        wlog.delete();
        spur = 1'b1;
        @(negedge clock);
        spur = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_spurious_writes", wlog.size(), 0);

        src_addr = 8'h60; dst_addr = 8'hD0; length = 9'd5; pidx = 0; resp_mask = 8'hFF;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        chk("third_send", dp_input_valid, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_outputs_zero("midrun_reset_outputs");
        wlog.delete();
        done_cnt = 0;
        repeat (5) @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        chk("post_reset_writes", wlog.size(), 0);
        chk("post_reset_done", done_cnt, 0);
        chk("post_reset_busy", busy, 1'b0);
        run(rv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
